mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   EX-stage multiply/divide unit beside the ALU. Takes the same A/B operand buses from ID/EX.
//   Its MDOut result feeds the EX result mux next to ALU output C.
//   Owns the HI/LO architectural registers and models multi-cycle mult/div latency with a
//   busy flag. The hazard unit stalls ID on that flag.
// PARAMETERS
//   MULT_CYCLES  5   cycles busy is high for mult/multu
//   DIV_CYCLES   10  cycles busy is high for div/divu
// PORTS
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-low reset; clears all state on its falling edge
//   start   in   1   one-cycle strobe; MDUOp is a mult/div op that must begin this cycle
//   MDUOp   in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//   A       in   32  rs operand (same bus as ALU A)
//   B       in   32  rt operand (same bus as ALU B)
//   busy    out  1   mult/div in progress
//   HI      out  32  HI register
//   LO      out  32  LO register
//   MDOut   out  32  combinational: HI if MDUOp=5, LO if MDUOp=6, else 0
// BEHAVIOUR
//   Reset (reset=0, any time, including mid-operation)
//   - HI=LO=0, busy=0, counter=0, state=IDLE, pending result discarded.
//   FSM states
//   - IDLE -> MUL when start=1 and MDUOp in {1,2}.
//   - IDLE -> DIV when start=1 and MDUOp in {3,4}.
//   - MUL/DIV -> IDLE when the counter expires.
//   Launch
//   - At the launch edge, operands are latched and the 64-bit result is computed into shadow
//     registers.
//   - Counter is loaded with N-1 (N = MULT_CYCLES or DIV_CYCLES). busy goes high at that edge.
//   Completion
//   - Counter decrements each edge while busy.
//   - On the edge where counter=0: HI/LO are written from the shadow registers, busy goes low,
//     state returns to IDLE.
//   - busy is therefore high for exactly N cycles. New HI/LO are visible N cycles after the launch edge.
//   Arithmetic
//   - mult: {HI,LO} = $signed(A)*$signed(B), 64-bit.
//   - multu: {HI,LO} = A*B, unsigned 64-bit.
//   - div: LO = quotient truncated toward zero; HI = remainder, sign of the dividend.
//   - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
//   - divu: LO = A/B, HI = A%B, unsigned.
//   - Divide by zero (B=0): operation still runs its full DIV_CYCLES; HI/LO are left unchanged.
//   mthi/mtlo (MDUOp 7/8)
//   - HI<=A or LO<=A at the next edge, only when busy=0; no busy cycles.
//   - Do not need start.
//   Ignored / undefined requests
//   - start while busy=1: ignored; the running op completes unaffected.
//   - mthi/mtlo while busy=1: ignored.
//   - Both cases are hazard-unit violations; the block only needs to stay consistent.
//   - start with a non-mult/div MDUOp: ignored.
//   mfhi/mflo while busy=1
//   - MDOut returns the old HI/LO. Stalling on busy|start is the hazard unit's job.
//   Same edge as completion
//   - mthi/mtlo on the completion edge is ignored, because busy=1 during that cycle.
//   - A new start at the edge after busy falls is accepted.
// TESTING
//   mult A=0xFFFFFFFE(-2), B=3
//   -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   multu A=0xFFFFFFFF, B=0xFFFFFFFF
//   -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//   div A=-7 (0xFFFFFFF9), B=2
//   -> busy 10 cycles, then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//   divu A=7, B=0 with HI=0x11, LO=0x22
//   -> busy 10 cycles, HI/LO still 0x11/0x22.
//   mthi A=0xDEADBEEF, then MDUOp=5
//   -> HI=0xDEADBEEF next cycle, MDOut=0xDEADBEEF, busy never asserted.
//   start div; reset low in cycle 4
//   -> busy=0, HI=LO=0 immediately; a new multu 2*3 after reset releases gives LO=6 after 5 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit that sits beside the ALU.
//
// Owns the HI/LO architectural registers. Models multi-cycle mult/div latency with a busy flag,
// which the hazard unit uses to stall ID. The 64-bit result is computed at the launch edge and
// held in a shadow register. It is committed to HI/LO when the latency counter expires.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset
//   start  in   1   one-cycle strobe launching a mult/div op given by MDUOp
//   MDUOp  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//   A      in   32  rs operand
//   B      in   32  rt operand
//   busy   out  1   mult/div in progress
//   HI     out  32  HI register
//   LO     out  32  LO register
//   MDOut  out  32  HI for mfhi, LO for mflo, else 0 (combinational)

module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [63:0]       shadow_q, shadow_d;   // {hi, lo} pending commit
    logic              commit_q, commit_d;   // cleared for divide by zero

    // Arithmetic on the live operand buses, sampled at the launch edge.
    logic [63:0] prod_s, prod_u;
    logic        div_ovf;
    logic [31:0] div_b;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 for B=0 (result discarded anyway) and for the signed overflow case,
    // where A/1 yields exactly the required quotient 0x80000000 with remainder 0.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign div_b   = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
    assign quo_s   = $signed(A) / $signed(div_b);
    assign rem_s   = $signed(A) % $signed(div_b);
    assign quo_u   = A / div_b;
    assign rem_u   = A % div_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        shadow_d = shadow_q;
        commit_d = commit_q;

        unique case (state_q)
            StIdle: begin
                if (start && (MDUOp == OpMult || MDUOp == OpMultu)) begin
                    state_d  = StMul;
                    cnt_d    = CntW'(MULT_CYCLES - 1);
                    shadow_d = (MDUOp == OpMult) ? prod_s : prod_u;
                    commit_d = 1'b1;
                end else if (start && (MDUOp == OpDiv || MDUOp == OpDivu)) begin
                    state_d  = StDiv;
                    cnt_d    = CntW'(DIV_CYCLES - 1);
                    shadow_d = (MDUOp == OpDiv) ? {rem_s, quo_s} : {rem_u, quo_u};
                    commit_d = (B != 32'd0);
                end else if (MDUOp == OpMthi) begin
                    hi_d = A;
                end else if (MDUOp == OpMtlo) begin
                    lo_d = A;
                end
            end
            StMul, StDiv: begin
                // start and mthi/mtlo are ignored while busy, including the completion edge.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (commit_q) begin
                        hi_d = shadow_q[63:32];
                        lo_d = shadow_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            shadow_q <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            shadow_q <= shadow_d;
            commit_q <= commit_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = (MDUOp == OpMfhi) ? hi_q :
                   (MDUOp == OpMflo) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, MDOut;

    int n_vec = 0;
    int n_bad = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called 1ns after an edge. Launches op at the next edge, then holds the "during" inputs
    // while busy. Returns busy length and MDOut sampled just after launch.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dstart, input logic [3:0] dop,
                          input logic [31:0] da, input logic [31:0] db,
                          output int cycles, output logic [31:0] first_md);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = dstart; MDUOp = dop; A = da; B = db;
        #1;
        first_md = MDOut;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(posedge clk); #2;
        end
        start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        #1;
    endtask

    int          cyc;
    logic [31:0] md;

    initial begin
        vecs[0] = '{"mult -2*3",        4'd1, 32'hFFFF_FFFE, 32'd3,
                    32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu max*max",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2] = '{"mult maxpos^2",    4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                    32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[3] = '{"mult minneg*2",    4'd1, 32'h8000_0000, 32'd2,
                    32'hFFFF_FFFF, 32'h0000_0000, 5};
        vecs[4] = '{"multu 2^31*2",     4'd2, 32'h8000_0000, 32'd2,
                    32'h0000_0001, 32'h0000_0000, 5};
        vecs[5] = '{"div -7/2",         4'd3, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[6] = '{"div 7/-2",         4'd3, 32'd7, 32'hFFFF_FFFE,
                    32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7] = '{"div overflow",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0000_0000, 32'h8000_0000, 10};
        vecs[8] = '{"divu big/16",      4'd4, 32'hFFFF_FFFF, 32'h10,
                    32'h0000_000F, 32'h0FFF_FFFF, 10};

        reset = 1'b0; start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        check("reset MDOut", MDOut, 32'd0);
        reset = 1'b1;

        // Table vectors: busy length and committed HI/LO.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 4'd0, '0, '0, cyc, md);
            check({vecs[i].name, " cycles"}, 32'(cyc), 32'(vecs[i].cyc));
            check({vecs[i].name, " HI"}, HI, vecs[i].hi);
            check({vecs[i].name, " LO"}, LO, vecs[i].lo);
        end

        // mthi / mtlo / mfhi / mflo
        MDUOp = 4'd7; A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        MDUOp = 4'd5; A = '0; #1;
        check("mthi HI", HI, 32'hDEAD_BEEF);
        check("mfhi MDOut", MDOut, 32'hDEAD_BEEF);
        check("mthi busy", {31'd0, busy}, 32'd0);
        MDUOp = 4'd8; A = 32'h22;
        @(posedge clk); #1;
        MDUOp = 4'd6; A = '0; #1;
        check("mflo MDOut", MDOut, 32'h22);
        MDUOp = 4'd7; A = 32'h11;
        @(posedge clk); #1;
        MDUOp = 4'd0; A = '0;
        check("mthi 0x11", HI, 32'h11);

        // Divide by zero: full latency, HI/LO untouched.
        run_op(4'd4, 32'd7, 32'd0, 1'b0, 4'd0, '0, '0, cyc, md);
        check("divu0 cycles", 32'(cyc), 32'd10);
        check("divu0 HI", HI, 32'h11);
        check("divu0 LO", LO, 32'h22);

        // mfhi while busy returns the old HI.
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 4'd5, '0, '0, cyc, md);
        check("mfhi busy old", md, 32'h11);
        check("mfhi busy cycles", 32'(cyc), 32'd5);
        check("mfhi busy HI", HI, 32'hFFFF_FFFF);

        // mthi held through the whole op, including the completion edge: ignored.
        run_op(4'd2, 32'd2, 32'd3, 1'b0, 4'd7, 32'h1234, '0, cyc, md);
        check("mthi ign cycles", 32'(cyc), 32'd5);
        check("mthi ign HI", HI, 32'd0);
        check("mthi ign LO", LO, 32'd6);

        // start while busy: running op completes unaffected.
        run_op(4'd1, 32'd3, 32'd5, 1'b1, 4'd4, 32'd100, 32'd7, cyc, md);
        check("start ign cycles", 32'(cyc), 32'd5);
        check("start ign HI", HI, 32'd0);
        check("start ign LO", LO, 32'd15);

        // Back-to-back: new start on the edge right after busy falls.
        run_op(4'd2, 32'd4, 32'd5, 1'b0, 4'd0, '0, '0, cyc, md);
        check("b2b first LO", LO, 32'd20);
        run_op(4'd4, 32'd20, 32'd3, 1'b0, 4'd0, '0, '0, cyc, md);
        check("b2b cycles", 32'(cyc), 32'd10);
        check("b2b HI", HI, 32'd2);
        check("b2b LO", LO, 32'd6);

        // start with a non-mult/div op is ignored.
        start = 1'b1; MDUOp = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0;
        check("start mfhi busy", {31'd0, busy}, 32'd0);

        // Reset mid-divide.
        start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid HI", HI, 32'd0);
        check("rst mid LO", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op(4'd2, 32'd2, 32'd3, 1'b0, 4'd0, '0, '0, cyc, md);
        check("post rst cycles", 32'(cyc), 32'd5);
        check("post rst HI", HI, 32'd0);
        check("post rst LO", LO, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
